// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and helpers for the HI/LO divide sequencer.
package hilo_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [31:0] DIVZ_LO_DEF = 32'hFFFF_FFFF;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/hilo_div_if.sv
// Link between the divide sequencer and the iterative divider.
interface hilo_div_if;

    logic [31:0] dv_dividend;
    logic [31:0] dv_divisor;
    logic        dv_start;
    logic [31:0] dv_q;
    logic [31:0] dv_r;
    logic        dv_busy;

    modport master (
        output dv_dividend,
        output dv_divisor,
        output dv_start,
        input  dv_q,
        input  dv_r,
        input  dv_busy
    );

    modport slave (
        input  dv_dividend,
        input  dv_divisor,
        input  dv_start,
        output dv_q,
        output dv_r,
        output dv_busy
    );

endinterface

// File: rtl/hilo_div_ctrl.sv
// DIV/DIVU sequencer: sign handling around the unsigned divider,
// HI/LO ownership and pipeline stall.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter logic [31:0] DIVZ_LO = DIVZ_LO_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] mt_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    hilo_div_if.master  dv
);

    state_t      state;
    state_t      state_nx;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        q_neg;
    logic        r_neg;
    logic        guard;
    logic        div_go;
    logic        done;
    logic        rs_neg;
    logic        rt_neg;

    assign div_go = div_req & (rt_val != 32'd0);
    assign rs_neg = div_signed & rs_val[31];
    assign rt_neg = div_signed & rt_val[31];
    assign done   = (state == RUN) & ~guard & ~dv.dv_busy;

    assign dv.dv_dividend = dividend;
    assign dv.dv_divisor  = divisor;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        dv.dv_start = 1'b0;
        stall       = 1'b1;
        unique case (state)
            IDLE: begin
                stall = div_go;
                if (div_go) begin
                    state_nx = START;
                end
            end
            START: begin
                dv.dv_start = 1'b1;
                state_nx    = RUN;
            end
            RUN: begin
                if (done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // guard masks the first RUN cycle, before busy reflects the launch
    always_ff @(posedge clock) begin
        if (reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            dividend <= 32'd0;
            divisor  <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            guard    <= 1'b0;
        end else begin
            guard <= (state == START);
            if (state == IDLE) begin
                if (div_go) begin
                    dividend <= rs_neg ? neg32(rs_val) : rs_val;
                    divisor  <= rt_neg ? neg32(rt_val) : rt_val;
                    q_neg    <= rs_neg ^ rt_neg;
                    r_neg    <= rs_neg;
                end else if (div_req) begin
                    hi <= rs_val;
                    lo <= DIVZ_LO;
                end else begin
                    if (hi_we) begin
                        hi <= mt_wdata;
                    end
                    if (lo_we) begin
                        lo <= mt_wdata;
                    end
                end
            end
            if (done) begin
                lo <= q_neg ? neg32(dv.dv_q) : dv.dv_q;
                hi <= r_neg ? neg32(dv.dv_r) : dv.dv_r;
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a negedge divider model.
module tb_hilo_div_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_req;
    logic        div_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] mt_wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    hilo_div_if dv();

    hilo_div_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .div_req    (div_req),
        .div_signed (div_signed),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .mt_wdata   (mt_wdata),
        .hi         (hi),
        .lo         (lo),
        .stall      (stall),
        .dv         (dv)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 32-cycle unsigned divider: busy from the start negedge for 32 negedges
    int          dcnt;
    logic [31:0] dq;
    logic [31:0] dr;

    initial begin
        dv.dv_busy = 1'b0;
        dv.dv_q    = 32'd0;
        dv.dv_r    = 32'd0;
        dcnt       = 0;
    end

    always @(negedge clock) begin
        if (reset) begin
            dv.dv_busy = 1'b0;
            dcnt       = 0;
        end else if (dv.dv_start) begin
            dv.dv_busy = 1'b1;
            dcnt       = 32;
            dq         = dv.dv_dividend / dv.dv_divisor;
            dr         = dv.dv_dividend % dv.dv_divisor;
            dv.dv_q    = 32'hA5A5_A5A5;
            dv.dv_r    = 32'h5A5A_5A5A;
        end else if (dv.dv_busy) begin
            dcnt--;
            if (dcnt == 0) begin
                dv.dv_busy = 1'b0;
                dv.dv_q    = dq;
                dv.dv_r    = dr;
            end
        end
    end

    // Architectural model: a division retires 33 edges after acceptance
    int          pend = 0;
    bit          mvalid = 1'b0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;

    always @(posedge clock) begin
        if (reset) begin
            pend   = 0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            mvalid = 1'b1;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                m_hi = r_hi;
                m_lo = r_lo;
            end
        end else if (div_req) begin
            if (rt_val == 32'd0) begin
                m_hi = rs_val;
                m_lo = 32'hFFFF_FFFF;
            end else begin
                pend = 33;
                if (div_signed) begin
                    sa   = longint'($signed(rs_val));
                    sb   = longint'($signed(rt_val));
                    sq   = sa / sb;
                    sr   = sa % sb;
                    r_lo = sq[31:0];
                    r_hi = sr[31:0];
                end else begin
                    r_lo = rs_val / rt_val;
                    r_hi = rs_val % rt_val;
                end
            end
        end else begin
            if (hi_we) m_hi = mt_wdata;
            if (lo_we) m_lo = mt_wdata;
        end
        #1;
        if (mvalid) begin
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("stall", {31'd0, stall},
                {31'd0, (pend > 0) || (div_req && rt_val != 32'd0)});
            chk("dv_start", {31'd0, dv.dv_start}, {31'd0, pend == 33});
        end
    end

    int n_stall;
    int n_start;

    task automatic step();
        #1;
        if (stall) n_stall++;
        if (dv.dv_start) n_start++;
        @(posedge clock);
        #2;
    endtask

    task automatic run_div(input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e_lo,
                           input logic [31:0] e_hi);
        n_stall    = 0;
        n_start    = 0;
        div_signed = sg;
        rs_val     = a;
        rt_val     = b;
        div_req    = 1'b1;
        step();
        div_req = 1'b0;
        repeat (36) step();
        chk("res_lo", lo, e_lo);
        chk("res_hi", hi, e_hi);
        chk("stall_cycles", n_stall, 34);
        chk("start_cycles", n_start, 1);
    endtask

    initial begin
        reset      = 1'b1;
        div_req    = 1'b0;
        div_signed = 1'b0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        mt_wdata   = 32'd0;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_start", {31'd0, dv.dv_start}, 32'd0);
        chk("rst_dividend", dv.dv_dividend, 32'd0);
        chk("rst_divisor", dv.dv_divisor, 32'd0);
        step();

        run_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

        n_stall    = 0;
        n_start    = 0;
        div_signed = 1'b0;
        rs_val     = 32'd5;
        rt_val     = 32'd0;
        div_req    = 1'b1;
        step();
        div_req = 1'b0;
        chk("divz_hi", hi, 32'd5);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        repeat (3) step();
        chk("divz_stall", n_stall, 0);
        chk("divz_start", n_start, 0);

        hi_we    = 1'b1;
        mt_wdata = 32'h0000_1234;
        step();
        hi_we = 1'b0;
        chk("mthi", hi, 32'h0000_1234);

        rs_val  = 32'd9;
        rt_val  = 32'd4;
        div_req = 1'b1;
        step();
        div_req = 1'b0;
        repeat (5) step();
        hi_we    = 1'b1;
        mt_wdata = 32'h0000_DEAD;
        step();
        hi_we = 1'b0;
        chk("mthi_in_run", hi, 32'h0000_1234);
        repeat (32) step();
        chk("div94_hi", hi, 32'd1);
        chk("div94_lo", lo, 32'd2);

        lo_we    = 1'b1;
        mt_wdata = 32'h0000_BEEF;
        rs_val   = 32'd8;
        rt_val   = 32'd2;
        div_req  = 1'b1;
        step();
        lo_we   = 1'b0;
        div_req = 1'b0;
        chk("mtlo_dropped", lo, 32'd2);
        repeat (36) step();
        chk("div82_lo", lo, 32'd4);
        chk("div82_hi", hi, 32'd0);

        div_signed = 1'b1;
        rs_val     = 32'hFFFF_FF9C;
        rt_val     = 32'd7;
        div_req    = 1'b1;
        step();
        div_req = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        repeat (40) step();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the 32-bit unsigned iterative divider.
- Accepts DIV/DIVU requests from the execute stage and converts signed operands to magnitudes.
- Pulses the divider's start, waits on its busy, applies sign correction to quotient/remainder, and writes the HI/LO architectural registers.
- Owns HI/LO (including MTHI/MTLO writes) and drives the pipeline stall while a division is outstanding.

Parameters:
- DIVZ_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero (HI receives the raw dividend).

Ports:
- clock  in  1  system clock; this block uses posedge, the divider uses negedge of the same clock.
- reset  in  1  synchronous, active-high.
- div_req  in  1  one-cycle request from execute for DIV/DIVU.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_req.
- rs_val  in  32  dividend; sampled with div_req.
- rt_val  in  32  divisor; sampled with div_req.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- mt_wdata  in  32  MTHI/MTLO data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall  out  1  pipeline stall.
- dv_dividend  out  32  magnitude dividend to divider.
- dv_divisor  out  32  magnitude divisor to divider.
- dv_start  out  1  divider start.
- dv_q  in  32  divider quotient.
- dv_r  in  32  divider remainder.
- dv_busy  in  1  divider busy.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state IDLE, hi=0, lo=0, dv_start=0, dv_dividend=0, dv_divisor=0, sign flags 0, stall=0.
- FSM states: IDLE, START, RUN.
- IDLE with div_req and rt_val != 0:
  - Latch magnitudes into dv_dividend/dv_divisor. When div_signed=1, a negative value is replaced by its two's-complement negation; 0x80000000 stays 0x80000000 and is treated as unsigned magnitude.
  - Latch q_neg = div_signed & (rs[31]^rt[31]) and r_neg = div_signed & rs[31]; go to START.
- IDLE with div_req and rt_val == 0: no divider launch. On that edge hi<=rs_val, lo<=DIVZ_LO; stay IDLE.
- START: dv_start=1 for exactly one cycle (dv_start = state==START). Next state RUN. The divider samples start at the following negedge; dv_start must never be high for two consecutive cycles, or the divider re-initialises.
- RUN:
  - The first RUN cycle ignores dv_busy (guard flag).
  - On subsequent edges with dv_busy==0: lo <= q_neg ? -dv_q : dv_q; hi <= r_neg ? -dv_r : dv_r; go to IDLE.
- stall = (state != IDLE) | (state==IDLE & div_req & rt_val != 0).
- Latency, req sampled at edge P0:
  - START during P0–P1.
  - Divider busy from N0 to N32.
  - HI/LO written at P33.
  - stall high for 34 cycles including the request cycle. A zero-divisor request completes in 1 cycle with no stall.
- MTHI/MTLO: applied only in IDLE. div_req in the same cycle has priority and the write is dropped. In START/RUN, hi_we/lo_we are ignored.
- div_req outside IDLE is ignored (the pipeline is stalled).
- hi/lo change only at a division completion, divide-by-zero, MT write, or reset.
- Reset mid-operation: next state IDLE with all reset values; the divider is reset by the same reset net. No HI/LO write from the aborted division.
- Signed overflow 0x80000000 / -1 needs no special case: it yields lo=0x80000000, hi=0.

Decomposition:
- Shared package: FSM state encoding (IDLE/START/RUN), DIVZ_LO default, a 32-bit two's-complement negate helper function.
- No sub-module: the sign pre/post logic is combinational inside this block.
- The divider is instantiated by the parent alongside this block, not inside it.

Test Plan:
- DIVU 7/2: lo=3, hi=1, stall high exactly 34 cycles, dv_start high exactly 1 cycle.
- DIV -7/2 (0xFFFFFFF9 / 2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2: lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1: lo=0xFFFFFFFF, hi=0.
- DIVU 5/0: hi=5, lo=0xFFFFFFFF on the same edge, stall=0 throughout, dv_start never asserted.
- MTHI 0x1234 in IDLE then DIVU 9/4: hi=0x1234 before and hi=1, lo=2 after. hi_we during RUN is ignored. div_req with lo_we in the same cycle drops the write.
- Reset asserted at cycle 10 of a DIV: state IDLE, hi=lo=0, stall=0 next cycle. A new DIVU 100/7 then gives lo=14, hi=2.
